gcd_stream_engine: RTL
======================

// Module: gcd_stream_engine
// PURPOSE
//  - Parametrised binary (Stein) GCD engine; next generation of the GCD datapath/FSM pair.
//  - Adds valid/ready streaming handshake, zero-operand handling, synchronous abort, one step per clock.
//  - Sits between an operand source (bus or FIFO) and a result consumer; one operation in flight.
// PARAMETERS
//  DATA_WIDTH  16                           operand/result width in bits (>=2)
//  SHIFT_W     $clog2(DATA_WIDTH)+1         common power-of-two shift counter width (localparam)
//  CNT_W       $clog2(3*DATA_WIDTH+4)       cycle counter width (localparam, used with GCD_CYCLES_EN)
// PORTS
//  clk_i        in   1           single clock, rising edge
//  nreset_i     in   1           asynchronous active-low reset
//  clear_i      in   1           synchronous abort; returns to IDLE, drops any result
//  in_valid_i   in   1           operand pair valid
//  in_ready_o   out  1           engine can accept operands (high only in IDLE)
//  operand_a_i  in   DATA_WIDTH  operand A
//  operand_b_i  in   DATA_WIDTH  operand B
//  out_valid_o  out  1           result valid (held until accepted)
//  out_ready_i  in   1           consumer accepts result
//  gcd_o        out  DATA_WIDTH  GCD result, stable while out_valid_o=1
//  zero_o       out  1           both operands were 0 (gcd_o=0); qualified by out_valid_o
//  cycles_o     out  CNT_W       ALIGN+REDUCE cycles used (only with GCD_CYCLES_EN)
// BEHAVIOUR
//  - Reset (nreset_i=0, async): state=IDLE; in_ready_o=1, out_valid_o=0, gcd_o=0, zero_o=0, cycles_o=0.
//  - Accept when in_valid_i&&in_ready_o at a rising edge: latch A,B; k=0; counter=0.
//    - A==0 or B==0: go to DONE next cycle, gcd_o=A|B, zero_o=(A==0&&B==0), no ALIGN/REDUCE.
//    - otherwise: go to ALIGN.
//  - ALIGN (1 cycle/step): if A,B both even -> A>>=1, B>>=1, k++; else -> REDUCE (no data change).
//  - REDUCE (1 cycle/step), priority order:
//    - A==B -> gcd_o = A<<k, DONE
//    - A even -> A>>=1
//    - B even -> B>>=1
//    - A>B -> A=A-B
//    - else B=B-A
//  - Arithmetic: unsigned, DATA_WIDTH bits; subtraction never underflows; A<<k never overflows (result<=min(A,B)).
//  - DONE: out_valid_o=1, gcd_o/zero_o/cycles_o frozen; when out_ready_i=1 -> IDLE next cycle.
//    - in_ready_o=0 in DONE: no same-cycle accept-on-pop; back-to-back gap is >=1 cycle.
//  - Latency acceptance->out_valid_o: 1 cycle for zero operands; otherwise 1+ALIGN+REDUCE cycles.
//    - Worst case <= 3*DATA_WIDTH+2.
//  - in_valid_i while busy is ignored (ready low); operands not sampled outside acceptance.
//  - clear_i has priority over every transition incl. accept: next state IDLE, out_valid_o=0, regs cleared.
//  - nreset_i asserted mid-operation: immediate IDLE, reset values; no partial result emitted.
//  - out_ready_i outside DONE: ignored.
// CONFIGURATION
//  - GCD_CYCLES_EN defined:
//    - CNT_W counter increments each ALIGN/REDUCE cycle, saturates at all-ones.
//    - Latched to cycles_o on entry to DONE; zero-operand results report 0.
//  - GCD_CYCLES_EN undefined: counter not built; cycles_o tied to 0 (port kept for stable interface).
// TESTING (DATA_WIDTH=16)
//  - A=48,B=18, out_ready_i=1 -> gcd_o=6, zero_o=0, single out_valid_o pulse.
//  - A=12,B=12 -> gcd_o=12; with GCD_CYCLES_EN cycles_o=4 (3 ALIGN + 1 REDUCE); A=7,B=7 -> cycles_o=2.
//  - A=0,B=0 -> gcd_o=0, zero_o=1 one cycle after accept; A=0,B=35 -> gcd_o=35, zero_o=0.
//  - A=65535,B=65534 -> gcd_o=1 within 50 cycles; A=32768,B=1024 -> gcd_o=1024.
//  - A=17,B=13, out_ready_i=0 for 10 cycles -> out_valid_o and gcd_o=1 held, in_ready_o=0;
//    - a new in_valid_i pulse during that time is not accepted.
//  - Abort: clear_i mid-REDUCE -> IDLE next cycle, no out_valid_o.
//    - nreset_i pulse mid-ALIGN -> all outputs at reset values.
//    - Next pair 21,14 -> gcd_o=7.

Source files
------------

// File: rtl/gcd_stream_engine.sv
// Binary (Stein) GCD engine with valid/ready streaming, zero-operand bypass and abort.
// Optional `GCD_CYCLES_EN builds a saturating ALIGN+REDUCE cycle counter on cycles_o.
module gcd_stream_engine #(
  parameter  int DATA_WIDTH = 16,
  localparam int SHIFT_W    = $clog2(DATA_WIDTH) + 1,
  localparam int CNT_W      = $clog2(3*DATA_WIDTH + 4)
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic                  zero_o,
  output logic [CNT_W-1:0]      cycles_o
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    REDUCE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [SHIFT_W-1:0]    k_q, k_d;
  logic [DATA_WIDTH-1:0] gcd_q, gcd_d;
  logic                  zero_q, zero_d;
  logic                  accept;
  logic                  opnd_zero;

  assign accept    = in_valid_i && (state_q == IDLE);
  assign opnd_zero = (operand_a_i == '0) || (operand_b_i == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    gcd_d   = gcd_q;
    zero_d  = zero_q;
    if (clear_i) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      k_d     = '0;
      gcd_d   = '0;
      zero_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_d    = operand_a_i;
            b_d    = operand_b_i;
            k_d    = '0;
            zero_d = 1'b0;
            if (opnd_zero) begin
              gcd_d   = operand_a_i | operand_b_i;
              zero_d  = (operand_a_i | operand_b_i) == '0;
              state_d = DONE;
            end else begin
              state_d = ALIGN;
            end
          end
        end
        ALIGN: begin
          if (!a_q[0] && !b_q[0]) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            k_d = k_q + SHIFT_W'(1);
          end else begin
            state_d = REDUCE;
          end
        end
        REDUCE: begin
          if (a_q == b_q) begin
            gcd_d   = a_q << k_q;
            state_d = DONE;
          end else if (!a_q[0]) begin
            a_d = a_q >> 1;
          end else if (!b_q[0]) begin
            b_d = b_q >> 1;
          end else if (a_q > b_q) begin
            a_d = a_q - b_q;
          end else begin
            b_d = b_q - a_q;
          end
        end
        DONE: begin
          if (out_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      gcd_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      gcd_q   <= gcd_d;
      zero_q  <= zero_d;
    end
  end

`ifdef GCD_CYCLES_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_inc;

  // The finishing REDUCE cycle counts too, so latch the incremented value.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    if (clear_i) begin
      cnt_d = '0;
      cyc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_d = '0;
            cyc_d = '0;
          end
        end
        ALIGN: cnt_d = cnt_inc;
        REDUCE: begin
          cnt_d = cnt_inc;
          if (a_q == b_q) cyc_d = cnt_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  assign cycles_o = cyc_q;
`else
  assign cycles_o = '0;
`endif

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign gcd_o       = gcd_q;
  assign zero_o      = zero_q;

endmodule
